// File: rtl/mc_control_if.sv
// ---------------------------------------------------------------------------
// mc_control_if
// Bundle between the multicycle control FSM and the MIPS datapath/ALU.
//   master : the control FSM (drives ALU op, mux selects, write enables;
//            receives the IR contents and the ALU result LSB)
//   slave  : the datapath side (the mirror image)
// Signals:
//   inst       32  instruction held in IR
//   alu_lsb     1  alu_result[0], branch condition
//   mem_ready   1  memory handshake, present only with MC_MEM_WAIT_EN
//   alu_funct   4  ALU operation
//   alu_src_a   1  0=PC, 1=rs
//   alu_src_b   2  0=rt, 1=4, 2=extended imm, 3=sext(imm)<<2
//   ext_zero    1  zero-extend immediate
//   pc_src      2  0=ALU, 1=ALUOut, 2=jump target, 3=rs
//   pc_write, ir_write, mem_read, mem_write, reg_write  enables
//   iord        1  0=PC address, 1=ALUOut address
//   reg_dst     2  0=rt, 1=rd, 2=link register
//   wb_sel      2  0=ALUOut, 1=MDR, 2=PC
// Optional macro: MC_MEM_WAIT_EN adds mem_ready.
// ---------------------------------------------------------------------------
interface mc_control_if;
    logic [31:0] inst;
    logic        alu_lsb;
`ifdef MC_MEM_WAIT_EN
    logic        mem_ready;
`endif
    logic [3:0]  alu_funct;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        ext_zero;
    logic [1:0]  pc_src;
    logic        pc_write;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  wb_sel;

`ifdef MC_MEM_WAIT_EN
    modport master (
        input  inst, alu_lsb, mem_ready,
        output alu_funct, alu_src_a, alu_src_b, ext_zero, pc_src, pc_write,
               ir_write, mem_read, mem_write, iord, reg_write, reg_dst, wb_sel
    );
    modport slave (
        output inst, alu_lsb, mem_ready,
        input  alu_funct, alu_src_a, alu_src_b, ext_zero, pc_src, pc_write,
               ir_write, mem_read, mem_write, iord, reg_write, reg_dst, wb_sel
    );
`else
    modport master (
        input  inst, alu_lsb,
        output alu_funct, alu_src_a, alu_src_b, ext_zero, pc_src, pc_write,
               ir_write, mem_read, mem_write, iord, reg_write, reg_dst, wb_sel
    );
    modport slave (
        output inst, alu_lsb,
        input  alu_funct, alu_src_a, alu_src_b, ext_zero, pc_src, pc_write,
               ir_write, mem_read, mem_write, iord, reg_write, reg_dst, wb_sel
    );
`endif
endinterface

// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control
// Multicycle MIPS control FSM: FETCH -> DECODE -> EXEC -> MEM -> WB.
// Decodes the instruction in IR, drives the ALU op and every datapath
// select/enable combinationally from the current state and instruction,
// and counts retired instructions.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   bus      if   mc_control_if.master (datapath controls, inst, alu_lsb)
//   illegal  out  one-cycle pulse in DECODE for an unsupported instruction
//   retired  out  retired-instruction count, wraps modulo 2^CNT_W
//   state    out  current state code, for debug
// Optional macro: MC_MEM_WAIT_EN -- FETCH and MEM wait for bus.mem_ready.
// ---------------------------------------------------------------------------
`ifndef ALU_ADDU
`define ALU_ADDU 4'd0
`define ALU_SUBU 4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_NOR  4'd5
`define ALU_SLT  4'd6
`define ALU_SLTU 4'd7
`define ALU_SLL  4'd8
`define ALU_SRL  4'd9
`define ALU_SRA  4'd10
`define ALU_LUI  4'd11
`define ALU_EQ   4'd12
`define ALU_NEQ  4'd13
`endif

module mc_control #(
    parameter int          CNT_W    = 32,
    parameter logic [4:0]  LINK_REG = 5'd31
) (
    input  logic              clk,
    input  logic              rst,
    mc_control_if.master      bus,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_retired;

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_mem_ready;

    // Instruction classes
    logic       w_is_r, w_is_jr, w_is_j, w_is_jal, w_is_br;
    logic       w_is_ialu, w_is_lw, w_is_sw, w_legal, w_zext;
    logic [3:0] w_r_funct, w_i_funct, w_br_funct;

    // Datapath controls
    logic [3:0] w_alu_funct;
    logic       w_alu_src_a, w_ext_zero, w_iord;
    logic [1:0] w_alu_src_b, w_pc_src, w_reg_dst, w_wb_sel;
    logic       w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_reg_write;
    logic       w_illegal, w_retire;

    // The link register number is applied by the datapath's reg_dst=2 leg;
    // rs/rt/rd/shamt/imm/target are consumed by the datapath, not here.
    logic       w_unused;
    assign w_unused = ^{LINK_REG, bus.inst[25:6]};

    assign w_op = bus.inst[31:26];
    assign w_fn = bus.inst[5:0];

`ifdef MC_MEM_WAIT_EN
    assign w_mem_ready = bus.mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    always_comb begin
        w_is_r     = 1'b0;
        w_is_jr    = 1'b0;
        w_is_j     = 1'b0;
        w_is_jal   = 1'b0;
        w_is_br    = 1'b0;
        w_is_ialu  = 1'b0;
        w_is_lw    = 1'b0;
        w_is_sw    = 1'b0;
        w_zext     = 1'b0;
        w_r_funct  = `ALU_ADDU;
        w_i_funct  = `ALU_ADDU;
        w_br_funct = `ALU_EQ;
        case (w_op)
            6'h00: begin
                case (w_fn)
                    6'h00: begin w_is_r = 1'b1; w_r_funct = `ALU_SLL;  end
                    6'h02: begin w_is_r = 1'b1; w_r_funct = `ALU_SRL;  end
                    6'h03: begin w_is_r = 1'b1; w_r_funct = `ALU_SRA;  end
                    6'h08: w_is_jr = 1'b1;
                    6'h20,
                    6'h21: begin w_is_r = 1'b1; w_r_funct = `ALU_ADDU; end
                    6'h22,
                    6'h23: begin w_is_r = 1'b1; w_r_funct = `ALU_SUBU; end
                    6'h24: begin w_is_r = 1'b1; w_r_funct = `ALU_AND;  end
                    6'h25: begin w_is_r = 1'b1; w_r_funct = `ALU_OR;   end
                    6'h26: begin w_is_r = 1'b1; w_r_funct = `ALU_XOR;  end
                    6'h27: begin w_is_r = 1'b1; w_r_funct = `ALU_NOR;  end
                    6'h2A: begin w_is_r = 1'b1; w_r_funct = `ALU_SLT;  end
                    6'h2B: begin w_is_r = 1'b1; w_r_funct = `ALU_SLTU; end
                    default: ;
                endcase
            end
            6'h02: w_is_j   = 1'b1;
            6'h03: w_is_jal = 1'b1;
            6'h04: begin w_is_br = 1'b1; w_br_funct = `ALU_EQ;  end
            6'h05: begin w_is_br = 1'b1; w_br_funct = `ALU_NEQ; end
            6'h09: begin w_is_ialu = 1'b1; w_i_funct = `ALU_ADDU; end
            6'h0A: begin w_is_ialu = 1'b1; w_i_funct = `ALU_SLT;  end
            6'h0B: begin w_is_ialu = 1'b1; w_i_funct = `ALU_SLTU; end
            6'h0C: begin w_is_ialu = 1'b1; w_i_funct = `ALU_AND; w_zext = 1'b1; end
            6'h0D: begin w_is_ialu = 1'b1; w_i_funct = `ALU_OR;  w_zext = 1'b1; end
            6'h0E: begin w_is_ialu = 1'b1; w_i_funct = `ALU_XOR; w_zext = 1'b1; end
            6'h0F: begin w_is_ialu = 1'b1; w_i_funct = `ALU_LUI;  end
            6'h23: w_is_lw = 1'b1;
            6'h2B: w_is_sw = 1'b1;
            default: ;
        endcase
    end

    assign w_legal = w_is_r | w_is_jr | w_is_j | w_is_jal | w_is_br |
                     w_is_ialu | w_is_lw | w_is_sw;

    always_comb begin
        w_next      = S_FETCH;
        w_alu_funct = `ALU_ADDU;
        w_alu_src_a = 1'b0;
        w_alu_src_b = 2'd0;
        w_ext_zero  = 1'b0;
        w_pc_src    = 2'd0;
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_iord      = 1'b0;
        w_reg_write = 1'b0;
        w_reg_dst   = 2'd0;
        w_wb_sel    = 2'd0;
        w_illegal   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                // Read IR and advance PC by 4 in the same cycle; while
                // memory stalls, the PC load is held off so it happens once.
                w_mem_read  = 1'b1;
                w_ir_write  = 1'b1;
                w_alu_src_b = 2'd1;
                w_pc_write  = w_mem_ready;
                w_next      = w_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target computed speculatively for EXEC.
                w_alu_src_b = 2'd3;
                if (!w_legal) begin
                    w_illegal = 1'b1;
                end else if (w_is_j || w_is_jal) begin
                    w_pc_src   = 2'd2;
                    w_pc_write = 1'b1;
                    w_retire   = 1'b1;
                    if (w_is_jal) begin
                        w_reg_write = 1'b1;
                        w_reg_dst   = 2'd2;
                        w_wb_sel    = 2'd2;
                    end
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_is_r) begin
                    w_alu_src_a = 1'b1;
                    w_alu_funct = w_r_funct;
                    w_next      = S_WB;
                end else if (w_is_jr) begin
                    w_alu_src_a = 1'b1;
                    w_pc_src    = 2'd3;
                    w_pc_write  = 1'b1;
                    w_retire    = 1'b1;
                end else if (w_is_ialu) begin
                    w_alu_src_a = 1'b1;
                    w_alu_src_b = 2'd2;
                    w_alu_funct = w_i_funct;
                    w_ext_zero  = w_zext;
                    w_next      = S_WB;
                end else if (w_is_lw || w_is_sw) begin
                    w_alu_src_a = 1'b1;
                    w_alu_src_b = 2'd2;
                    w_next      = S_MEM;
                end else if (w_is_br) begin
                    // ALUOut still holds the target from DECODE.
                    w_alu_src_a = 1'b1;
                    w_alu_funct = w_br_funct;
                    w_pc_src    = 2'd1;
                    w_pc_write  = bus.alu_lsb;
                    w_retire    = 1'b1;
                end
            end
            S_MEM: begin
                w_iord = 1'b1;
                if (w_is_lw) begin
                    w_mem_read = 1'b1;
                    w_next     = w_mem_ready ? S_WB : S_MEM;
                end else if (w_is_sw) begin
                    w_mem_write = 1'b1;
                    w_retire    = w_mem_ready;
                    w_next      = w_mem_ready ? S_FETCH : S_MEM;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = w_is_r  ? 2'd1 : 2'd0;
                w_wb_sel    = w_is_lw ? 2'd1 : 2'd0;
                w_retire    = 1'b1;
            end
            default: ;
        endcase
        // Reset abandons any instruction in flight without side effects.
        if (rst) begin
            w_pc_write  = 1'b0;
            w_ir_write  = 1'b0;
            w_mem_read  = 1'b0;
            w_mem_write = 1'b0;
            w_reg_write = 1'b0;
            w_illegal   = 1'b0;
            w_retire    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.alu_funct = w_alu_funct;
    assign bus.alu_src_a = w_alu_src_a;
    assign bus.alu_src_b = w_alu_src_b;
    assign bus.ext_zero  = w_ext_zero;
    assign bus.pc_src    = w_pc_src;
    assign bus.pc_write  = w_pc_write;
    assign bus.ir_write  = w_ir_write;
    assign bus.mem_read  = w_mem_read;
    assign bus.mem_write = w_mem_write;
    assign bus.iord      = w_iord;
    assign bus.reg_write = w_reg_write;
    assign bus.reg_dst   = w_reg_dst;
    assign bus.wb_sel    = w_wb_sel;

    assign illegal = w_illegal;
    assign retired = r_retired;
    assign state   = r_state;

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle MIPS control FSM. It is the issuing end of the ALU interface.
- Decodes the 32-bit instruction held in IR and sequences FETCH/DECODE/EXEC/MEM/WB.
- Per state, drives the ALU funct code (`ALU_* from GLOBAL.v) and all datapath mux and write-enable controls.
- Takes the ALU result LSB back as the branch condition.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- LINK_REG, 5'd31, destination register for JAL.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- inst  in  32  instruction from IR; stable from DECODE until return to FETCH.
- alu_lsb  in  1  alu_result[0]; branch condition in EXEC.
- alu_funct  out  4  ALU op, `ALU_* encoding.
- alu_src_a  out  1  0=PC, 1=rs.
- alu_src_b  out  2  0=rt, 1=const 4, 2=extended imm, 3=sext(imm)<<2.
- ext_zero  out  1  1=zero-extend imm (ANDI/ORI/XORI), else sign-extend.
- pc_src  out  2  0=ALU result, 1=ALUOut reg, 2={PC[31:28],target,2'b00}, 3=rs.
- pc_write  out  1  PC load enable.
- ir_write  out  1  IR load enable.
- mem_read  out  1  memory read.
- mem_write  out  1  memory write.
- iord  out  1  0=PC address, 1=ALUOut address.
- reg_write  out  1  register-file write.
- reg_dst  out  2  0=rt, 1=rd, 2=LINK_REG.
- wb_sel  out  2  0=ALUOut, 1=MDR, 2=PC (link).
- illegal  out  1  one-cycle pulse on unsupported opcode/funct.
- retired  out  CNT_W  retired-instruction count.
- state  out  3  current state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5-7 go to FETCH next cycle with no enables asserted.
- Outputs are combinational from state and inst. Unlisted outputs are 0.
- Reset:
  - rst high forces state=FETCH and retired=0 at the next edge.
  - While rst is high, all enables (pc_write, ir_write, mem_read, mem_write, reg_write) and illegal are 0.
  - Reset mid-instruction abandons it with no further writes.
- FETCH:
  - mem_read=1, iord=0, ir_write=1.
  - ALU computes PC+4: alu_src_a=0, alu_src_b=1, ADDU; pc_src=0, pc_write=1.
  - Next state: DECODE.
- DECODE:
  - ALU computes branch target: src_a=0, src_b=3, ADDU.
  - J: pc_src=2, pc_write=1, then FETCH.
  - JAL: J actions plus reg_write=1, reg_dst=2, wb_sel=2, then FETCH.
  - Unsupported: illegal=1, then FETCH with no writes; not retired.
  - Otherwise: EXEC.
- EXEC:
  - R-type: src_a=1, src_b=0. Funct map: ADDU/ADD→ALU_ADDU, SUBU/SUB→ALU_SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA. Next: WB.
  - JR: pc_src=3, pc_write=1. Next: FETCH.
  - ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI: src_a=1, src_b=2, matching ALU op; ext_zero=1 for ANDI/ORI/XORI. Next: WB.
  - LW/SW: src_a=1, src_b=2, ADDU. Next: MEM.
  - BEQ/BNE: src_a=1, src_b=0, ALU_EQ/ALU_NEQ; pc_src=1, pc_write=alu_lsb. Next: FETCH.
- MEM:
  - iord=1.
  - LW: mem_read=1, then WB.
  - SW: mem_write=1, then FETCH.
- WB:
  - reg_write=1.
  - reg_dst=1 for R-type, else 0.
  - wb_sel=1 for LW, else 0.
  - Next: FETCH.
- Retirement:
  - retired increments on the final cycle of each legal instruction.
  - Wraps modulo 2^CNT_W.
- Instruction cycle counts: J/JAL 2, branch/JR 3, R/I-ALU/SW 4, LW 5.
- Multiple-write conflict: pc_write, reg_write and mem_write may assert together only as listed above, never otherwise.

Optional Feature:
- Macro MC_MEM_WAIT_EN adds input mem_ready (1 bit).
- With the macro:
  - FETCH holds, with all enables asserted and pc_write gated by mem_ready, until mem_ready=1.
  - MEM holds until mem_ready=1; mem_write is asserted every waiting cycle.
- Without the macro: no port; memory completes in one cycle.

Test Plan:
- rst=1 for 2 cycles mid-LW (state=MEM) → state=0 and retired=0 after the edge; no mem/reg write pulses during rst.
- ADDU $3,$1,$2 (0x00221821) → states 0,1,2,4,0; EXEC alu_funct=`ALU_ADDU, src_a=1, src_b=0; WB reg_write=1, reg_dst=1; retired +1.
- LW $2,4($1) then SW → LW takes 5 cycles with MEM mem_read=1, iord=1 and WB wb_sel=1; SW takes 4 cycles with mem_write=1 exactly once.
- BEQ twice, alu_lsb=1 then 0 → 3 cycles each; EXEC pc_write=1 then 0, pc_src=1, alu_funct=`ALU_EQ. BNE → `ALU_NEQ.
- JAL 0x0040 → 2 cycles; DECODE pc_src=2, pc_write=1, reg_write=1, reg_dst=2, wb_sel=2.
- Opcode 0x3F → illegal pulses 1 cycle in DECODE, returns to FETCH, retired unchanged. With MC_MEM_WAIT_EN, mem_ready low 3 cycles → FETCH held 4 cycles with a single pc_write.
